// File: rtl/decimator_pkg.sv
// Shared types and helpers for the decimator runtime controller.
package decimator_pkg;

  localparam int DEFAULT_FACTOR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  // A factor of zero has no period, and the phase must fall inside one period.
  function automatic logic cfg_legal(input logic [31:0] factor, input logic [31:0] phase);
    return (factor != 32'd0) && (phase < factor);
  endfunction

endpackage

// File: rtl/decimator_ctrl_if.sv
// Config handshake bundle between the register block (master) and the controller (slave).
interface decimator_ctrl_if
  import decimator_pkg::*;
#(
  parameter int FACTOR_WIDTH = DEFAULT_FACTOR_WIDTH
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [FACTOR_WIDTH-1:0] cfg_factor;
  logic [FACTOR_WIDTH-1:0] cfg_phase;
  logic                    cfg_err;

  modport master (output cfg_valid, output cfg_factor, output cfg_phase,
                  input  cfg_ready, input  cfg_err);
  modport slave  (input  cfg_valid, input  cfg_factor, input  cfg_phase,
                  output cfg_ready, output cfg_err);
endinterface

// File: rtl/decimator_phase_counter.sv
// Modulo-factor sample counter with synchronous clear and a combinational wrap flag.
module decimator_phase_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic [WIDTH-1:0] factor,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = step && (count == factor - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (step) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/decimator_ctrl.sv
// Decimator runtime controller: config handshake, start/stop/sync FSM and capture strobe.
// Optional build macros: DECIMATOR_CTRL_STATS_EN (sample statistics), SYNC_REQUIRED (start waits for sync_in).
module decimator_ctrl
  import decimator_pkg::*;
#(
  parameter int FACTOR_WIDTH   = DEFAULT_FACTOR_WIDTH,
  parameter int DEFAULT_FACTOR = 8,
  parameter int DEFAULT_PHASE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  decimator_ctrl_if.slave    cfg,
  input  logic               start,
  input  logic               stop,
  input  logic               sync_in,
  input  logic               in_valid,
  output logic               sample_en,
  output logic               busy,
  output logic [1:0]         state_o
`ifdef DECIMATOR_CTRL_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        in_cnt,
  output logic [31:0]        out_cnt
`endif
);

`ifdef SYNC_REQUIRED
  localparam state_t START_TARGET = WAIT_SYNC;
`else
  localparam state_t START_TARGET = RUN;
`endif

  state_t                  state, nxt;
  logic [FACTOR_WIDTH-1:0] factor, phase, sh_factor, sh_phase, count;
  logic                    pending, cfg_err_q;
  logic                    cnt_clr, cnt_step, cnt_wrap;
  logic                    cfg_xfer, cfg_ok, hold_run, apply_pending;

  assign cfg.cfg_ready = !pending;
  assign cfg.cfg_err   = cfg_err_q;
  assign cfg_xfer      = cfg.cfg_valid && !pending;
  assign cfg_ok        = cfg_legal(32'(cfg.cfg_factor), 32'(cfg.cfg_phase));

  assign cnt_step  = en && (state == RUN) && in_valid;
  assign sample_en = cnt_step && (count == phase);
  assign busy      = (state != IDLE);
  assign state_o   = state;

  // A config arriving while RUN continues must wait for a period boundary; stopping applies it at once.
  assign hold_run      = (state == RUN) && !(en && stop);
  assign apply_pending = pending && en && (state == RUN) && (cnt_wrap || stop);

  decimator_phase_counter #(.WIDTH(FACTOR_WIDTH)) u_phase_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .step   (cnt_step),
    .factor (factor),
    .count  (count),
    .wrap   (cnt_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt     = state;
    cnt_clr = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            nxt     = START_TARGET;
            cnt_clr = 1'b1;
          end
        end
        WAIT_SYNC: begin
          if (stop) nxt = IDLE;
          else if (sync_in) begin
            nxt     = RUN;
            cnt_clr = 1'b1;
          end
        end
        RUN: begin
          if (stop)         nxt     = IDLE;
          else if (sync_in) cnt_clr = 1'b1;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      factor    <= FACTOR_WIDTH'(DEFAULT_FACTOR);
      phase     <= FACTOR_WIDTH'(DEFAULT_PHASE);
      sh_factor <= '0;
      sh_phase  <= '0;
      pending   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_xfer && !cfg_ok;
      if (apply_pending) begin
        factor  <= sh_factor;
        phase   <= sh_phase;
        pending <= 1'b0;
      end
      // cfg_xfer implies !pending, so this never collides with apply_pending.
      if (cfg_xfer && cfg_ok) begin
        if (hold_run) begin
          sh_factor <= cfg.cfg_factor;
          sh_phase  <= cfg.cfg_phase;
          pending   <= 1'b1;
        end else begin
          factor <= cfg.cfg_factor;
          phase  <= cfg.cfg_phase;
        end
      end
    end
  end

`ifdef DECIMATOR_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (stats_clr) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (cnt_step)  in_cnt  <= in_cnt + 32'd1;
      if (sample_en) out_cnt <= out_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decimator_ctrl.sv
// Self-checking bench for decimator_ctrl: vector table, directed corner sequences, random run vs model.
module tb_decimator_ctrl;
  import decimator_pkg::*;

`ifdef SYNC_REQUIRED
  localparam bit SYNC_REQ = 1'b1;
`else
  localparam bit SYNC_REQ = 1'b0;
`endif
  localparam int SYNC_ST = SYNC_REQ ? 1 : 2;

  logic clk = 1'b0;
  logic rst, en, start, stop, sync_in, in_valid;
  logic sample_en, busy;
  logic [1:0] state_o;
`ifdef DECIMATOR_CTRL_STATS_EN
  logic stats_clr;
  logic [31:0] in_cnt, out_cnt;
`endif

  decimator_ctrl_if #(.FACTOR_WIDTH(16)) cfg_if ();

  decimator_ctrl #(.FACTOR_WIDTH(16), .DEFAULT_FACTOR(8), .DEFAULT_PHASE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg_if),
    .start     (start),
    .stop      (stop),
    .sync_in   (sync_in),
    .in_valid  (in_valid),
    .sample_en (sample_en),
    .busy      (busy),
    .state_o   (state_o)
`ifdef DECIMATOR_CTRL_STATS_EN
    ,
    .stats_clr (stats_clr),
    .in_cnt    (in_cnt),
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample position counted from the last alignment, period test by modulo.
  int m_st, m_factor, m_phase, m_shf, m_shp, m_pos;
  bit m_pending, m_err;

  task automatic model_reset();
    m_st = 0; m_factor = 8; m_phase = 0; m_shf = 0; m_shp = 0;
    m_pos = 0; m_pending = 0; m_err = 0;
  endtask

  function automatic bit model_se();
    return en && (m_st == 2) && in_valid && ((m_pos % m_factor) == m_phase);
  endfunction

  task automatic model_update();
    int  f, p, n_pos;
    bit  xfer, legal, adv, wrap, stop_run, apply;
    f        = int'(cfg_if.cfg_factor);
    p        = int'(cfg_if.cfg_phase);
    xfer     = cfg_if.cfg_valid && !m_pending;
    legal    = (f != 0) && (p < f);
    adv      = en && (m_st == 2) && in_valid;
    wrap     = adv && ((m_pos % m_factor) == m_factor - 1);
    stop_run = en && (m_st == 2) && stop;
    apply    = m_pending && (wrap || stop_run);
    n_pos    = adv ? m_pos + 1 : m_pos;
    m_err    = xfer && !legal;
    if (apply) begin
      m_factor = m_shf; m_phase = m_shp; m_pending = 0; n_pos = 0;
    end
    if (xfer && legal) begin
      if ((m_st == 2) && !stop_run) begin
        m_shf = f; m_shp = p; m_pending = 1;
      end else begin
        m_factor = f; m_phase = p;
      end
    end
    if (en) begin
      if (m_st == 0) begin
        if (start && !stop) begin m_st = SYNC_REQ ? 1 : 2; n_pos = 0; end
      end else if (m_st == 1) begin
        if (stop) m_st = 0;
        else if (sync_in) begin m_st = 2; n_pos = 0; end
      end else begin
        if (stop) m_st = 0;
        else if (sync_in) n_pos = 0;
      end
    end
    m_pos = n_pos;
  endtask

  logic       s_se, s_rdy, s_err, s_busy;
  logic [1:0] s_st;

  // One clock: sample outputs mid-cycle, compare with the model, advance the model, step past the edge.
  task automatic tick();
    @(negedge clk);
    s_se = sample_en; s_rdy = cfg_if.cfg_ready; s_err = cfg_if.cfg_err;
    s_st = state_o;   s_busy = busy;
    check("model_sample_en", s_se, model_se());
    check("model_cfg_ready", s_rdy, !m_pending);
    check("model_cfg_err", s_err, m_err);
    check("model_state", s_st, m_st);
    check("model_busy", s_busy, m_st != 0);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en = 1'b1; start = 1'b0; stop = 1'b0; sync_in = 1'b0; in_valid = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_factor = '0; cfg_if.cfg_phase = '0;
`ifdef DECIMATOR_CTRL_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_if.cfg_ready, 1);
    check("rst_cfg_err", cfg_if.cfg_err, 0);
    check("rst_sample_en", sample_en, 0);
    rst = 1'b0;
  endtask

  task automatic start_and_sync();
    start = 1'b1;   tick(); start = 1'b0;
    sync_in = 1'b1; tick(); sync_in = 1'b0;
  endtask

  task automatic send_cfg(input int f, input int p);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_factor = 16'(f); cfg_if.cfg_phase = 16'(p);
  endtask

  typedef struct {
    logic cv; logic [15:0] f, p; logic st, sp, sy, iv;
    logic e_se, e_rdy, e_err; logic [1:0] e_st;
  } vec_t;

  function automatic vec_t v(int cv, int f, int p, int st, int sp, int sy, int iv,
                             int se, int rdy, int err, int state);
    vec_t r;
    r.cv = cv != 0; r.f = 16'(f); r.p = 16'(p);
    r.st = st != 0; r.sp = sp != 0; r.sy = sy != 0; r.iv = iv != 0;
    r.e_se = se != 0; r.e_rdy = rdy != 0; r.e_err = err != 0; r.e_st = 2'(state);
    return r;
  endfunction

  vec_t vecs[22];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Illegal configs leave defaults; then factor 3 phase 2 with alternate-cycle samples.
    vecs[0]  = v(0,0,0, 0,0,0,0, 0,1,0,0);
    vecs[1]  = v(1,0,0, 0,0,0,0, 0,1,0,0);
    vecs[2]  = v(0,0,0, 0,0,0,0, 0,1,1,0);
    vecs[3]  = v(1,4,4, 0,0,0,0, 0,1,0,0);
    vecs[4]  = v(0,0,0, 0,0,0,0, 0,1,1,0);
    vecs[5]  = v(1,3,2, 0,0,0,0, 0,1,0,0);
    vecs[6]  = v(0,0,0, 0,0,0,0, 0,1,0,0);
    vecs[7]  = v(0,0,0, 1,0,0,0, 0,1,0,0);
    vecs[8]  = v(0,0,0, 0,0,1,0, 0,1,0,SYNC_ST);
    vecs[9]  = v(0,0,0, 0,0,0,1, 0,1,0,2);
    vecs[10] = v(0,0,0, 0,0,0,0, 0,1,0,2);
    vecs[11] = v(0,0,0, 0,0,0,1, 0,1,0,2);
    vecs[12] = v(0,0,0, 0,0,0,0, 0,1,0,2);
    vecs[13] = v(0,0,0, 0,0,0,1, 1,1,0,2);
    vecs[14] = v(0,0,0, 0,0,0,0, 0,1,0,2);
    vecs[15] = v(0,0,0, 0,0,0,1, 0,1,0,2);
    vecs[16] = v(0,0,0, 0,0,0,0, 0,1,0,2);
    vecs[17] = v(0,0,0, 0,0,0,1, 0,1,0,2);
    vecs[18] = v(0,0,0, 0,0,0,0, 0,1,0,2);
    vecs[19] = v(0,0,0, 0,0,0,1, 1,1,0,2);
    vecs[20] = v(0,0,0, 0,1,0,0, 0,1,0,2);
    vecs[21] = v(0,0,0, 0,0,0,0, 0,1,0,0);

    rst = 1'b1;
    clear_inputs();

    do_reset();
    foreach (vecs[i]) begin
      cfg_if.cfg_valid = vecs[i].cv; cfg_if.cfg_factor = vecs[i].f; cfg_if.cfg_phase = vecs[i].p;
      start = vecs[i].st; stop = vecs[i].sp; sync_in = vecs[i].sy; in_valid = vecs[i].iv;
      tick();
      check($sformatf("vec%0d_sample_en", i), s_se, vecs[i].e_se);
      check($sformatf("vec%0d_cfg_ready", i), s_rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d_cfg_err", i), s_err, vecs[i].e_err);
      check($sformatf("vec%0d_state", i), s_st, vecs[i].e_st);
    end
    clear_inputs();

    // Defaults: strobe on valid samples 0, 8, 16.
    do_reset();
    start_and_sync();
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      check("dflt_sample_en", s_se, (i % 8) == 0);
      check("dflt_state", s_st, 2);
      check("dflt_busy", s_busy, 1);
    end
    in_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0; tick();

    // Config during RUN waits for the wrap, then period 4 starts from count 0.
    do_reset();
    start_and_sync();
    in_valid = 1'b1;
    repeat (3) tick();
    send_cfg(4, 0);
    tick();
    check("shadow_accept_ready", s_rdy, 1);
    cfg_if.cfg_valid = 1'b0;
    for (int i = 4; i < 8; i++) begin
      tick();
      check("shadow_pending_ready", s_rdy, 0);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      check("shadow_new_period", s_se, (i % 4) == 0);
      check("shadow_ready_back", s_rdy, 1);
    end
    in_valid = 1'b0;

    // Mid-RUN sync re-aligns the next sample; en low freezes everything.
    do_reset();
    start_and_sync();
    in_valid = 1'b1;
    repeat (5) tick();
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    check("sync_old_count", s_se, 0);
    tick();
    check("sync_realigned", s_se, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_low_no_strobe", s_se, 0);
      check("en_low_state", s_st, 2);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("en_resume_count", s_se, i == 7);
    end
    in_valid = 1'b0;

    // Asynchronous reset with a config pending restores defaults immediately.
    do_reset();
    start_and_sync();
    in_valid = 1'b1;
    repeat (2) tick();
    send_cfg(2, 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();
    check("pend_before_rst", s_rdy, 0);
    rst = 1'b1;
    clear_inputs();
    #1;
    check("async_rst_state", state_o, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cfg_if.cfg_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_and_sync();
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("post_rst_default", s_se, (i % 8) == 0);
    end
    in_valid = 1'b0;

`ifdef DECIMATOR_CTRL_STATS_EN
    do_reset();
    start_and_sync();
    in_valid = 1'b1;
    repeat (64) tick();
    in_valid = 1'b0;
    check("stats_in_cnt", in_cnt, 64);
    check("stats_out_cnt", out_cnt, 8);
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    check("stats_clr_in", in_cnt, 0);
    check("stats_clr_out", out_cnt, 0);
`endif

    // Random traffic against the model, including illegal and mid-run configs.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en               = $urandom_range(0, 9) != 0;
      start            = $urandom_range(0, 15) == 0;
      stop             = $urandom_range(0, 49) == 0;
      sync_in          = $urandom_range(0, 29) == 0;
      in_valid         = $urandom_range(0, 2) != 0;
      cfg_if.cfg_valid = $urandom_range(0, 11) == 0;
      cfg_if.cfg_factor = 16'($urandom_range(0, 6));
      cfg_if.cfg_phase  = 16'($urandom_range(0, 6));
      tick();
    end
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
